// File: rtl/tick_divider.sv
// Programmable tick / clock-enable generator with run, pause and restart control.
// Produces a one-cycle tick every div_reg cycles and a square wave toggling on each tick.
module tick_divider #(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 125000000,
  parameter int TCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic              div_load,
  input  logic [CNT_W-1:0]  div_val,
  output logic              tick,
  output logic              clk_div,
  output logic              running,
  output logic [TCNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_reg_q, div_reg_d;
  logic [CNT_W-1:0]   div_pend_q, div_pend_d;
  logic               pend_v_q, pend_v_d;
  logic               start_d_q, start_d_d;
  logic               tick_q, tick_d;
  logic               clk_div_q, clk_div_d;
  logic               running_q, running_d;
  logic [TCNT_W-1:0]  tick_count_q, tick_count_d;
  logic               start_rise;
  logic               wrap;

  assign start_rise = start & ~start_d_q;
  assign wrap       = (cnt_q == (div_reg_q - CNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_reg_d    = div_reg_q;
    div_pend_d   = div_pend_q;
    pend_v_d     = pend_v_q;
    start_d_d    = start;
    tick_d       = 1'b0;
    clk_div_d    = clk_div_q;
    tick_count_d = tick_count_q;

    if (!start) begin
      state_d   = IDLE;
      cnt_d     = '0;
      clk_div_d = 1'b0;
      pend_v_d  = 1'b0;
      // A load on the cycle we are already idle still counts as an idle load.
      if (div_load && state_q == IDLE) div_reg_d = clamp_div(div_val);
    end else if (start_rise) begin
      state_d      = RUN;
      cnt_d        = '0;
      tick_count_d = '0;
      clk_div_d    = 1'b0;
      pend_v_d     = 1'b0;
      if (div_load) div_reg_d = clamp_div(div_val);
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (div_load) div_reg_d = clamp_div(div_val);
        end
        RUN, PAUSE: begin
          if (hold) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            if (wrap) begin
              cnt_d        = '0;
              tick_d       = 1'b1;
              clk_div_d    = ~clk_div_q;
              tick_count_d = tick_count_q + TCNT_W'(1);
              if (pend_v_q) begin
                div_reg_d = div_pend_q;
                pend_v_d  = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          // Placed after the wrap so a coincident load becomes the next pending value.
          if (div_load) begin
            div_pend_d = clamp_div(div_val);
            pend_v_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_reg_q    <= DEF_DIV;
      div_pend_q   <= '0;
      pend_v_q     <= 1'b0;
      start_d_q    <= 1'b0;
      tick_q       <= 1'b0;
      clk_div_q    <= 1'b0;
      running_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_reg_q    <= div_reg_d;
      div_pend_q   <= div_pend_d;
      pend_v_q     <= pend_v_d;
      start_d_q    <= start_d_d;
      tick_q       <= tick_d;
      clk_div_q    <= clk_div_d;
      running_q    <= running_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign tick       = tick_q;
  assign clk_div    = clk_div_q;
  assign running    = running_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider: per-cycle vector table for period/pause,
// then hand sequences for restart, run-time loads, clamp, wrap and mid-run reset.
module tb_tick_divider;

  localparam int CNT_W  = 8;
  localparam int TCNT_W = 2;

  logic              clk = 1'b0;
  logic              rst, start, hold, div_load;
  logic [CNT_W-1:0]  div_val;
  logic              tick, clk_div, running;
  logic [TCNT_W-1:0] tick_count;

  tick_divider #(.CNT_W(CNT_W), .DEFAULT_DIV(5), .TCNT_W(TCNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .div_load(div_load), .div_val(div_val),
    .tick(tick), .clk_div(clk_div), .running(running), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st, hd, r;
    bit t, c, rn, chk_rn;
    int tc;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;

  task automatic add(input bit st, hd, r, t, c, rn, chk_rn, input int tc);
    vec_t v;
    v.st = st; v.hd = hd; v.r = r;
    v.t = t; v.c = c; v.rn = rn; v.chk_rn = chk_rn; v.tc = tc;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until tick is seen; -1 if it never appears within maxc edges.
  task automatic wait_tick(input int maxc, output int cnt);
    cnt = 0;
    for (int i = 0; i < maxc; i++) begin
      step();
      cnt++;
      if (tick === 1'b1) return;
    end
    cnt = -1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; div_load = 1'b0; div_val = '0;

    // reset, idle, basic period N=5, then a 3-cycle hold at cnt=2
    add(0,0,1, 0,0,0,1,0);
    add(0,0,1, 0,0,0,1,0);
    add(0,0,0, 0,0,0,1,0);
    add(1,0,0, 0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(1,0,0, 0,0,1,1,0);
    add(1,0,0, 1,1,1,1,1);
    for (int i = 0; i < 4; i++) add(1,0,0, 0,1,1,1,1);
    add(1,0,0, 1,0,1,1,2);
    for (int i = 0; i < 4; i++) add(1,0,0, 0,0,1,1,2);
    add(1,0,0, 1,1,1,1,3);
    for (int i = 0; i < 2; i++) add(1,0,0, 0,1,1,1,3);
    for (int i = 0; i < 3; i++) add(1,1,0, 0,1,0,1,3);
    for (int i = 0; i < 2; i++) add(1,0,0, 0,1,1,1,3);
    add(1,0,0, 1,0,1,1,0);

    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].st; hold = vq[i].hd; rst = vq[i].r;
      step();
      chk($sformatf("v%0d_tick", i), int'(tick), int'(vq[i].t));
      chk($sformatf("v%0d_clk_div", i), int'(clk_div), int'(vq[i].c));
      if (vq[i].chk_rn) chk($sformatf("v%0d_running", i), int'(running), int'(vq[i].rn));
      chk($sformatf("v%0d_tick_count", i), int'(tick_count), vq[i].tc);
    end

    // restart: drop start at cnt=3, then raise again
    wait_tick(8, n);  chk("pre_restart_period", n, 5);
    chk("pre_restart_tc", int'(tick_count), 1);
    step(); step(); step();
    start = 1'b0; step();
    chk("drop_tick", int'(tick), 0);
    chk("drop_clk_div", int'(clk_div), 0);
    chk("drop_running", int'(running), 0);
    chk("drop_tc_hold", int'(tick_count), 1);
    start = 1'b1; step();
    chk("restart_tc", int'(tick_count), 0);
    chk("restart_clk_div", int'(clk_div), 0);
    wait_tick(8, n);  chk("restart_period", n, 5);
    chk("restart_running", int'(running), 1);

    // run-time load of 3 at cnt=1
    step();
    div_load = 1'b1; div_val = 8'd3; step();
    div_load = 1'b0;
    wait_tick(8, n);  chk("load_cur_period_rest", n, 3);
    wait_tick(8, n);  chk("load_new_period_a", n, 3);
    wait_tick(8, n);  chk("load_new_period_b", n, 3);

    // two loads before the wrap: last one wins
    div_load = 1'b1; div_val = 8'd2; step();
    div_val = 8'd4; step();
    div_load = 1'b0;
    wait_tick(8, n);  chk("double_load_cur", n, 1);
    wait_tick(8, n);  chk("double_load_a", n, 4);
    wait_tick(8, n);  chk("double_load_b", n, 4);

    // clamp: idle load of 0 gives N=2; 5 ticks wrap the 2-bit count to 1
    start = 1'b0; step();
    div_load = 1'b1; div_val = 8'd0; step();
    div_load = 1'b0; start = 1'b1; step();
    for (int i = 0; i < 5; i++) begin
      wait_tick(6, n);  chk($sformatf("clamp_period_%0d", i), n, 2);
    end
    chk("wrap_tc", int'(tick_count), 1);
    chk("wrap_clk_div", int'(clk_div), 1);

    // reset mid-period with N=3, start held through reset
    start = 1'b0; step();
    div_load = 1'b1; div_val = 8'd3; step();
    div_load = 1'b0; start = 1'b1; step();
    wait_tick(8, n);  chk("rst_pre_period", n, 3);
    chk("rst_pre_tc", int'(tick_count), 1);
    step();
    rst = 1'b1; step();
    chk("rst_tick", int'(tick), 0);
    chk("rst_clk_div", int'(clk_div), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_tc", int'(tick_count), 0);
    rst = 1'b0;
    wait_tick(10, n); chk("post_rst_default_div", n, 6);
    wait_tick(10, n); chk("post_rst_period", n, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
